// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: shared FSM state encoding and tile-count width for the tile scheduler
package tile_sched_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_W_REQ,
    S_W_WAIT,
    S_C_REQ,
    S_C_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/tile_counter.sv
// tile_counter: wrapping tile index counter with clear, enable and terminal-count flag
//   clk, rst  : clock, synchronous active-high reset
//   i_clr     : force count to 0 (wins over i_en)
//   i_en      : advance count, wrapping i_max -> 0
//   i_max     : terminal count value
//   o_count   : registered count
//   o_nxt     : value o_count takes at the next edge
//   o_is_max  : o_count == i_max
module tile_counter
  import tile_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_max,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_nxt,
  output logic             o_is_max
);
  logic [CNT_W-1:0] r_count;
  assign o_count  = r_count;
  assign o_is_max = r_count == i_max;
  assign o_nxt    = i_clr ? '0 : i_en ? (o_is_max ? '0 : r_count + 1'b1) : r_count;
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= o_nxt;
  end
endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a layer's (i_ch, o_ch) tiles, handshaking weight load and compute per tile
//   clk, rst          : clock, synchronous active-high reset
//   start_in          : layer start, sampled in IDLE only
//   w_done_in         : weight load finished (honoured in W_WAIT only)
//   c_done_in         : tile compute finished (honoured in C_WAIT only)
//   w_start_out       : one-cycle weight-load pulse
//   c_start_out       : one-cycle compute pulse
//   i_ch_count_out    : input-channel tile index (outer loop)
//   o_ch_count_out    : output-channel tile index (inner loop)
//   acc_en_out        : accumulate onto partial sum (i_ch tile != 0)
//   last_i_ch_out     : final input-channel tile
//   busy_out          : layer in progress, W_REQ through DONE
//   done_out          : one-cycle layer-complete pulse
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int MAC_ROW           = 16,
  parameter int MAC_COL           = 16,
  parameter int IFMAP_CHANNEL_NUM = 32,
  parameter int OFMAP_CHANNEL_NUM = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             w_done_in,
  input  logic             c_done_in,
  output logic             w_start_out,
  output logic             c_start_out,
  output logic [CNT_W-1:0] i_ch_count_out,
  output logic [CNT_W-1:0] o_ch_count_out,
  output logic             acc_en_out,
  output logic             last_i_ch_out,
  output logic             busy_out,
  output logic             done_out
);
  localparam int I_TILES = IFMAP_CHANNEL_NUM / MAC_ROW;
  localparam int O_TILES = OFMAP_CHANNEL_NUM / MAC_COL;
  localparam logic [CNT_W-1:0] I_MAX = CNT_W'(I_TILES - 1);
  localparam logic [CNT_W-1:0] O_MAX = CNT_W'(O_TILES - 1);

  if (IFMAP_CHANNEL_NUM % MAC_ROW != 0 || I_TILES < 1 || I_TILES > 256) begin : g_bad_i
    $error("tile_scheduler: IFMAP_CHANNEL_NUM/MAC_ROW must divide evenly into 1..256 tiles");
  end
  if (OFMAP_CHANNEL_NUM % MAC_COL != 0 || O_TILES < 1 || O_TILES > 256) begin : g_bad_o
    $error("tile_scheduler: OFMAP_CHANNEL_NUM/MAC_COL must divide evenly into 1..256 tiles");
  end

  state_t           r_state, w_state_nxt;
  logic             w_clr, w_o_en, w_i_en, w_o_max, w_i_max, w_last;
  logic [CNT_W-1:0] w_i_nxt, w_o_nxt_unused;
  logic             w_w_start, w_c_start, w_done, w_busy, w_acc, w_last_i;

  assign w_last = w_o_max && w_i_max;
  assign w_clr  = r_state == S_IDLE && start_in;
  // Counts move only when a non-final tile completes; the final tile leaves them holding.
  assign w_o_en = r_state == S_C_WAIT && c_done_in && !w_last;
  assign w_i_en = w_o_en && w_o_max;

  tile_counter u_o_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_o_en),
    .i_max    (O_MAX),
    .o_count  (o_ch_count_out),
    .o_nxt    (w_o_nxt_unused),
    .o_is_max (w_o_max)
  );

  tile_counter u_i_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_i_en),
    .i_max    (I_MAX),
    .o_count  (i_ch_count_out),
    .o_nxt    (w_i_nxt),
    .o_is_max (w_i_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      w_start_out   <= 1'b0;
      c_start_out   <= 1'b0;
      done_out      <= 1'b0;
      busy_out      <= 1'b0;
      acc_en_out    <= 1'b0;
      last_i_ch_out <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      w_start_out   <= w_w_start;
      c_start_out   <= w_c_start;
      done_out      <= w_done;
      busy_out      <= w_busy;
      acc_en_out    <= w_acc;
      last_i_ch_out <= w_last_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = start_in  ? S_W_REQ : S_IDLE;
      S_W_REQ:  w_state_nxt = S_W_WAIT;
      S_W_WAIT: w_state_nxt = w_done_in ? S_C_REQ : S_W_WAIT;
      S_C_REQ:  w_state_nxt = S_C_WAIT;
      S_C_WAIT: w_state_nxt = c_done_in ? (w_last ? S_DONE : S_W_REQ) : S_C_WAIT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and next i_ch count so the registered copies line up with the state.
  always_comb begin
    w_w_start = w_state_nxt == S_W_REQ;
    w_c_start = w_state_nxt == S_C_REQ;
    w_done    = w_state_nxt == S_DONE;
    w_busy    = w_state_nxt != S_IDLE;
    w_acc     = w_busy && w_i_nxt != '0;
    w_last_i  = w_busy && w_i_nxt == I_MAX;
  end
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: directed self-checking bench for tile_scheduler (2x4 tiles and 1x1 tile builds)
module tb_tile_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_in = 1'b0, w_done_in = 1'b0, c_done_in = 1'b0;
  logic w_start_out, c_start_out, acc_en_out, last_i_ch_out, busy_out, done_out;
  logic [7:0] i_ch_count_out, o_ch_count_out;
  logic start1 = 1'b0, w_done1 = 1'b1, c_done1 = 1'b1;
  logic w_start1, c_start1, acc_en1, last_i_ch1, busy1, done1;
  logic [7:0] i_cnt1, o_cnt1;
  logic [21:0] obs, obs1;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk(clk), .rst(rst), .start_in(start_in), .w_done_in(w_done_in), .c_done_in(c_done_in),
    .w_start_out(w_start_out), .c_start_out(c_start_out),
    .i_ch_count_out(i_ch_count_out), .o_ch_count_out(o_ch_count_out),
    .acc_en_out(acc_en_out), .last_i_ch_out(last_i_ch_out), .busy_out(busy_out), .done_out(done_out)
  );

  tile_scheduler #(.IFMAP_CHANNEL_NUM(16), .OFMAP_CHANNEL_NUM(16)) dut1 (
    .clk(clk), .rst(rst), .start_in(start1), .w_done_in(w_done1), .c_done_in(c_done1),
    .w_start_out(w_start1), .c_start_out(c_start1),
    .i_ch_count_out(i_cnt1), .o_ch_count_out(o_cnt1),
    .acc_en_out(acc_en1), .last_i_ch_out(last_i_ch1), .busy_out(busy1), .done_out(done1)
  );

  assign obs  = {w_start_out, c_start_out, done_out, busy_out, acc_en_out, last_i_ch_out,
                 i_ch_count_out, o_ch_count_out};
  assign obs1 = {w_start1, c_start1, done1, busy1, acc_en1, last_i_ch1, i_cnt1, o_cnt1};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if (obs !== 22'b0) begin n_bad++; $display("FAIL reset_main got %b exp %b", obs, 22'b0); end
    n_cmp++;
    if (obs1 !== 22'b0) begin n_bad++; $display("FAIL reset_single got %b exp %b", obs1, 22'b0); end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (obs !== 22'b0) begin n_bad++; $display("FAIL reset_release got %b exp %b", obs, 22'b0); end
  endtask

  // Full 2x4 layer with both dones held high; start_in is re-pulsed at cycles s1 and s2 after acceptance.
  task automatic run_full_layer(input string tag, input int s1, input int s2);
    w_done_in = 1'b1;
    c_done_in = 1'b1;
    start_in  = 1'b1;
    tick;
    start_in  = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      logic [21:0] e;
      logic [7:0] ei, eo;
      int t, p;
      t  = (k - 1) / 4;
      p  = (k - 1) % 4;
      ei = 8'(t / 4);
      eo = 8'(t % 4);
      e  = (k == 33) ? {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 8'd3}
                     : {p == 0, p == 2, 1'b0, 1'b1, ei != 8'd0, ei == 8'd1, ei, eo};
      start_in = (k == s1 || k == s2);
      n_cmp++;
      if (obs !== e) begin n_bad++; $display("FAIL %s k=%0d got %b exp %b", tag, k, obs, e); end
      tick;
    end
    start_in = 1'b0;
    n_cmp++;
    if ({obs[21:18], obs[15:0]} !== {4'b0000, 8'd1, 8'd3})
      begin n_bad++; $display("FAIL %s_idle got %b exp %b", tag, {obs[21:18], obs[15:0]}, {4'b0000, 8'd1, 8'd3}); end
    tick;
    n_cmp++;
    if (obs[21:18] !== 4'b0000) begin n_bad++; $display("FAIL %s_idle2 got %b exp 0000", tag, obs[21:18]); end
  endtask

  task automatic test_basic;
    run_full_layer("basic", 0, 0);
  endtask

  task automatic test_random_delays;
    int dw[8] = '{0, 3, 10, 1, 7, 2, 5, 4};
    int dc[8] = '{6, 0, 2, 9, 1, 10, 3, 0};
    w_done_in = 1'b0;
    c_done_in = 1'b0;
    start_in  = 1'b1;
    tick;
    start_in  = 1'b0;
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < dw[t] + dc[t] + 4; j++) begin
        logic [17:0] e, o;
        w_done_in = (j == dw[t] + 1);
        c_done_in = (j == dw[t] + dc[t] + 3);
        e = {j == 0, j == dw[t] + 2, 8'(t / 4), 8'(t % 4)};
        o = {w_start_out, c_start_out, i_ch_count_out, o_ch_count_out};
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL delays t=%0d j=%0d got %b exp %b", t, j, o, e); end
        tick;
      end
    end
    w_done_in = 1'b0;
    c_done_in = 1'b0;
    n_cmp++;
    if ({done_out, busy_out, w_start_out} !== 3'b110)
      begin n_bad++; $display("FAIL delays_done got %b exp 110", {done_out, busy_out, w_start_out}); end
    tick;
    n_cmp++;
    if ({done_out, busy_out} !== 2'b00) begin n_bad++; $display("FAIL delays_idle got %b exp 00", {done_out, busy_out}); end
  endtask

  task automatic test_ignored_dones;
    logic [19:0] exp_wait;
    bit seen;
    exp_wait  = {1'b0, 1'b0, 1'b1, 8'd0, 8'd0};
    w_done_in = 1'b0;
    c_done_in = 1'b0;
    start_in  = 1'b1;
    tick;
    start_in  = 1'b0;
    tick;
    c_done_in = 1'b1;
    tick;
    c_done_in = 1'b0;
    n_cmp++;
    if ({w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out} !== exp_wait)
      begin n_bad++; $display("FAIL cdone_in_wwait got %b exp %b", {w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out}, exp_wait); end
    tick;
    n_cmp++;
    if ({w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out} !== exp_wait)
      begin n_bad++; $display("FAIL wwait_hold got %b exp %b", {w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out}, exp_wait); end
    w_done_in = 1'b1;
    tick;
    w_done_in = 1'b0;
    n_cmp++;
    if (c_start_out !== 1'b1) begin n_bad++; $display("FAIL creq_pulse got %b exp 1", c_start_out); end
    w_done_in = 1'b1;
    c_done_in = 1'b1;
    tick;
    w_done_in = 1'b0;
    c_done_in = 1'b0;
    n_cmp++;
    if ({w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out} !== exp_wait)
      begin n_bad++; $display("FAIL dones_in_creq got %b exp %b", {w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out}, exp_wait); end
    tick;
    n_cmp++;
    if ({w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out} !== exp_wait)
      begin n_bad++; $display("FAIL cwait_hold got %b exp %b", {w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out}, exp_wait); end
    w_done_in = 1'b1;
    c_done_in = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick;
      seen = done_out;
    end
    n_cmp++;
    if (seen !== 1'b1 || i_ch_count_out !== 8'd1 || o_ch_count_out !== 8'd3)
      begin n_bad++; $display("FAIL ignored_finish got done=%b i=%0d o=%0d exp done=1 i=1 o=3", seen, i_ch_count_out, o_ch_count_out); end
    w_done_in = 1'b0;
    c_done_in = 1'b0;
    tick;
  endtask

  task automatic test_start_ignored;
    run_full_layer("start_mid", 9, 33);
    run_full_layer("restart", 0, 0);
  endtask

  task automatic test_reset_mid;
    w_done_in = 1'b1;
    c_done_in = 1'b1;
    start_in  = 1'b1;
    tick;
    start_in  = 1'b0;
    repeat (27) tick;
    n_cmp++;
    if ({w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out} !== {3'b001, 8'd1, 8'd2})
      begin n_bad++; $display("FAIL pre_rst got %b exp %b", {w_start_out, c_start_out, busy_out, i_ch_count_out, o_ch_count_out}, {3'b001, 8'd1, 8'd2}); end
    rst      = 1'b1;
    start_in = 1'b1;
    tick;
    rst      = 1'b0;
    start_in = 1'b0;
    n_cmp++;
    if (obs !== 22'b0) begin n_bad++; $display("FAIL mid_rst got %b exp %b", obs, 22'b0); end
    tick;
    n_cmp++;
    if (obs !== 22'b0) begin n_bad++; $display("FAIL mid_rst_hold got %b exp %b", obs, 22'b0); end
    run_full_layer("after_rst", 0, 0);
  endtask

  task automatic test_single_tile;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      logic [21:0] e;
      e = {k == 1, k == 3, k == 5, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0};
      n_cmp++;
      if (obs1 !== e) begin n_bad++; $display("FAIL single k=%0d got %b exp %b", k, obs1, e); end
      tick;
    end
    n_cmp++;
    if (obs1[21:18] !== 4'b0000) begin n_bad++; $display("FAIL single_idle got %b exp 0000", obs1[21:18]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random_delays;
    test_ignored_dones;
    test_start_ignored;
    test_reset_mid;
    test_single_tile;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
